serial_a_paralelo: RTL and testbench
====================================

# serial_a_paralelo

Serial-to-parallel receiver: the far end of the team's parallel-to-serial link. It takes a 1-bit MSB-first stream clocked at bit rate, finds byte alignment from the comma symbol, and declares the link active after a run of consecutive commas. Once active, it delivers each non-comma byte as a parallel word with a one-cycle valid strobe. It sits between the serial channel and the byte-wide datapath, built from the team's DFF/DFFSR-style flops.

## Interface
- `WIDTH`, 8: symbol width in bits.
- `COM`, 8'hBC: comma/idle symbol used for alignment (K28.5 byte).
- `NCOM`, 4: consecutive aligned commas required before `active` asserts (≥1).

Ports:
- `C`  in  1: bit-rate clock; all state changes on its rising edge.
- `R`  in  1: reset, asynchronous, active-high.
- `data_in`  in  1: serial data, MSB of each symbol first.
- `data_out`  out  WIDTH: last received non-comma byte.
- `valid_out`  out  1: one-cycle strobe; `data_out` holds a new byte.
- `active`  out  1: link aligned and past the comma preamble.

## Operation
- Shift register `sr` (WIDTH bits) runs on every edge: `sr_next = {sr[WIDTH-2:0], data_in}`.
- Bit counter `bc` (0..WIDTH-1). A byte boundary is an edge where `bc == WIDTH-1`. `bc` wraps to 0 there.
- Comma counter `cc` is sized to hold `NCOM`.
- State UNALIGNED (reset state):
  - `bc` is ignored.
  - If `sr_next == COM` at an edge: set `cc <= 1` and `bc <= 0`, and go to ALIGNING. If `NCOM == 1`, go directly to ACTIVE instead.
- State ALIGNING:
  - At a boundary with `sr_next == COM`: `cc <= cc+1`. When `cc+1 == NCOM`, go to ACTIVE.
  - At a boundary with `sr_next != COM`: go to UNALIGNED with `cc <= 0`. No re-scan happens on that same edge.
- State ACTIVE:
  - At a boundary with `sr_next != COM`: `data_out <= sr_next`, `valid_out <= 1`.
  - At a boundary with `sr_next == COM` (idle): `valid_out <= 0`, `data_out` holds.
  - ACTIVE is left only by reset. Loss of alignment is not detected in this block.
- `valid_out` is 0 on every non-boundary edge, so it is never high on two consecutive cycles.
- `active` is 1 exactly while the state is ACTIVE.
- Asserting `R` at any time, including mid-byte, immediately clears everything:
  - `sr=0`, `bc=0`, `cc=0`, state UNALIGNED.
  - `data_out=0`, `valid_out=0`, `active=0`.
  - Alignment must be reacquired from scratch after release.

## Timing
- All outputs are registered. Reset values: `data_out=0`, `valid_out=0`, `active=0`.
- The first comma is recognised on the edge that samples its last bit (LSB). That edge is the byte-0 boundary, and subsequent boundaries fall every WIDTH edges after it.
- `active` rises after the edge that samples the LSB of the NCOM-th consecutive aligned comma.
- Data latency: `data_out` and `valid_out` update on the edge that samples a byte's LSB and are visible until the next edge.
- Throughput: one byte per WIDTH clocks, with no bubbles beyond the commas themselves.
- An all-commas stream after ACTIVE produces no strobes.
- A COM pattern straddling two data bytes while in ACTIVE is ignored, because comparison happens only at boundaries.
- Deasserting `R` synchronously to `C` is the integrator's responsibility. The first edge after release samples `data_in` normally.

## Test plan
- Reset check: hold `R=1` for 3 cycles while `data_in` toggles → `data_out=00`, `valid_out=0`, `active=0`, no strobes.
- Acquisition with arbitrary offset:
  - Stimulus: 3 random bits, then 4×BC, then bytes 01, 55, FF.
  - Required: `active` rises after the LSB of the 4th BC.
  - Required: `valid_out` pulses exactly 3 times with `data_out` = 01, 55, FF, each pulse spaced 8 clocks apart.
- Idle insertion: in ACTIVE, send 3C, BC, BC, A7 → strobes only for 3C and A7. `data_out` stays 3C through both BC periods.
- Broken preamble: send BC, BC, 12, then 4×BC, then 99 → `active` stays 0 until the second run completes, then a single strobe with 99.
- False comma: in ACTIVE, send 0B, C0 (bit stream contains BC across the boundary) → two strobes, 0B then C0, with no realignment.
- Mid-byte reset: assert `R` 3 bits into a data byte while in ACTIVE → all outputs clear immediately. Resend 4×BC, then 42 → `active` rises again and one strobe with 42.

Source files
------------

// File: rtl/serial_a_paralelo.sv
// -----------------------------------------------------------------------------
// serial_a_paralelo
//
// Serial-to-parallel receiver for the parallel-to-serial link. It takes an
// MSB-first bit stream at bit rate, finds byte alignment from the comma symbol
// COM, and declares the link active after NCOM consecutive aligned commas.
// Once active, every non-comma byte is presented on data_out together with a
// one-cycle valid_out strobe. Commas received while active are idle fill.
//
// Parameters:
//   WIDTH : symbol width in bits
//   COM   : comma / idle symbol used for alignment
//   NCOM  : consecutive aligned commas required before active asserts (>= 1)
//
// Ports:
//   C         in   bit-rate clock, rising edge
//   R         in   asynchronous reset, active high
//   data_in   in   serial data, MSB of each symbol first
//   data_out  out  last received non-comma byte (holds across idles)
//   valid_out out  one-cycle strobe, data_out holds a new byte
//   active    out  link aligned and past the comma preamble
//   state_dbg out  current FSM state encoding, for observation only
//
// Handshake: valid_out is a push-only strobe with no ready; it is high for
// exactly one C cycle per delivered byte, and data_out is stable from that
// strobe until the next one.
// -----------------------------------------------------------------------------
module serial_a_paralelo #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] COM  = 8'hBC,
    parameter int              NCOM  = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active,
    output logic [1:0]       state_dbg
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CCW = $clog2(NCOM + 1);

    typedef enum logic [1:0] {
        UNALIGNED = 2'd0,
        ALIGNING  = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [BCW-1:0]   bc, bc_n;
    logic [CCW-1:0]   cc, cc_n, cc_inc;
    logic [WIDTH-1:0] data_n;
    logic             valid_n;
    logic             boundary;
    logic             is_com;

    // State register and all registered outputs.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state     <= UNALIGNED;
            sr        <= '0;
            bc        <= '0;
            cc        <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            bc        <= bc_n;
            cc        <= cc_n;
            data_out  <= data_n;
            valid_out <= valid_n;
            active    <= (state_n == ACTIVE);
        end
    end

    assign state_dbg = state;

    // Next-state and next-output logic.
    always_comb begin
        sr_n     = {sr[WIDTH-2:0], data_in};
        boundary = (bc == BCW'(WIDTH - 1));
        is_com   = (sr_n == COM);
        cc_inc   = cc + CCW'(1);

        state_n  = state;
        bc_n     = boundary ? '0 : bc + BCW'(1);
        cc_n     = cc;
        data_n   = data_out;
        valid_n  = 1'b0;

        case (state)
            UNALIGNED: begin
                // Bit phase is unknown here, so the comparison runs on every
                // edge; a hit fixes the byte-0 boundary at this very edge.
                bc_n = bc;
                if (is_com) begin
                    cc_n    = CCW'(1);
                    bc_n    = '0;
                    state_n = (NCOM == 1) ? ACTIVE : ALIGNING;
                end
            end
            ALIGNING: begin
                if (boundary) begin
                    if (is_com) begin
                        cc_n = cc_inc;
                        if (cc_inc == CCW'(NCOM)) begin
                            state_n = ACTIVE;
                        end
                    end else begin
                        // Broken preamble: drop back and start scanning on the
                        // next edge, not this one.
                        cc_n    = '0;
                        state_n = UNALIGNED;
                    end
                end
            end
            ACTIVE: begin
                // Only boundaries are inspected, so a comma pattern straddling
                // two data bytes is ignored.
                if (boundary && !is_com) begin
                    data_n  = sr_n;
                    valid_n = 1'b1;
                end
            end
            default: begin
                state_n = UNALIGNED;
                cc_n    = '0;
                bc_n    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_a_paralelo.sv
// -----------------------------------------------------------------------------
// tb_serial_a_paralelo
//
// Drives directed and randomized bit streams into serial_a_paralelo and
// compares every cycle against a bit-history reference model that tracks the
// absolute edge number of the next byte boundary.
// -----------------------------------------------------------------------------
module tb_serial_a_paralelo;

    localparam int         NCOM = 4;
    localparam logic [7:0] COM  = 8'hBC;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [1:0] state_dbg;

    serial_a_paralelo #(.WIDTH(8), .COM(COM), .NCOM(NCOM)) dut (
        .C         (clk),
        .R         (rst),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // mode: 0 = searching for comma, 1 = counting preamble commas, 2 = linked
    int         m_win;
    int         m_mode;
    int         m_run;
    int         m_n = 0;
    int         m_next;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_active;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         strobe_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_win    = 0;
        m_mode   = 0;
        m_run    = 0;
        m_next   = 0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        m_win   = ((m_win << 1) | int'(b)) & 255;
        m_valid = 1'b0;
        if (m_mode == 0) begin
            if (m_win == int'(COM)) begin
                m_run  = 1;
                m_next = m_n + 8;
                m_mode = (NCOM == 1) ? 2 : 1;
            end
        end else if (m_n == m_next) begin
            m_next = m_n + 8;
            if (m_mode == 1) begin
                if (m_win == int'(COM)) begin
                    m_run++;
                    if (m_run == NCOM) m_mode = 2;
                end else begin
                    m_mode = 0;
                    m_run  = 0;
                end
            end else if (m_win != int'(COM)) begin
                m_data  = 8'(m_win);
                m_valid = 1'b1;
            end
        end
        m_active = (m_mode == 2);
    endtask

    task automatic check_outputs();
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("active", 32'(active), 32'(m_active));
        if (valid_out === 1'b1) begin
            got_q.push_back(data_out);
            strobe_cyc.push_back(m_n);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_bit(input logic b);
        @(negedge clk);
        data_in = b;
        @(posedge clk);
        m_n++;
        if (rst) model_reset();
        else     model_edge(b);
        #1;
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_commas(input int n);
        for (int i = 0; i < n; i++) send_byte(COM);
    endtask

    // Assert reset mid-cycle, check the outputs clear at once, hold a couple of
    // edges, then release well ahead of the next rising edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_data", 32'(data_out), 32'h0);
        chk("async_rst_valid", 32'(valid_out), 32'h0);
        chk("async_rst_active", 32'(active), 32'h0);
        send_bit(1'($urandom_range(0, 1)));
        send_bit(1'($urandom_range(0, 1)));
        rst = 1'b0;
    endtask

    task automatic begin_scn();
        got_q.delete();
        strobe_cyc.delete();
        exp_q.delete();
    endtask

    task automatic end_scn(input string tag);
        int n;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    function automatic logic [7:0] rand_data();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        while (v == COM) v = 8'($urandom_range(0, 255));
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v;
        model_reset();

        // Reset state, held for three cycles with toggling data.
        #1;
        rst = 1'b1;
        #1;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        begin_scn();
        for (int i = 0; i < 3; i++) send_bit(1'(i % 2));
        rst = 1'b0;
        end_scn("reset");

        // Acquisition at an arbitrary bit offset.
        begin_scn();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        send_commas(3);
        chk("pre_active", 32'(active), 32'h0);
        send_commas(1);
        chk("active_rise", 32'(active), 32'h1);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'hFF);
        exp_q = '{8'h01, 8'h55, 8'hFF};
        end_scn("acquire");
        if (strobe_cyc.size() == 3) begin
            chk("spacing_0", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd8);
            chk("spacing_1", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd8);
        end

        // Random payload while linked.
        begin_scn();
        for (int i = 0; i < 6; i++) begin
            v = rand_data();
            exp_q.push_back(v);
            send_byte(v);
        end
        end_scn("rand_payload");

        // Idle insertion.
        begin_scn();
        send_byte(8'h3C);
        send_byte(COM);
        chk("idle_hold_0", 32'(data_out), 32'h3C);
        send_byte(COM);
        chk("idle_hold_1", 32'(data_out), 32'h3C);
        send_byte(8'hA7);
        exp_q = '{8'h3C, 8'hA7};
        end_scn("idle");

        // Broken preamble.
        async_reset();
        begin_scn();
        send_commas(2);
        send_byte(8'h12);
        chk("broken_inactive_0", 32'(active), 32'h0);
        send_commas(3);
        chk("broken_inactive_1", 32'(active), 32'h0);
        send_commas(1);
        chk("broken_active", 32'(active), 32'h1);
        send_byte(8'h99);
        exp_q = '{8'h99};
        end_scn("broken");

        // Comma pattern straddling a byte boundary.
        begin_scn();
        send_byte(8'h0B);
        send_byte(8'hC0);
        exp_q = '{8'h0B, 8'hC0};
        end_scn("false_comma");

        // Reset three bits into a data byte.
        begin_scn();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        async_reset();
        send_commas(4);
        chk("reacquire_active", 32'(active), 32'h1);
        send_byte(8'h42);
        exp_q = '{8'h42};
        end_scn("midbyte_reset");

        // Randomized mix of idles and data.
        begin_scn();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_byte(COM);
            end else begin
                v = rand_data();
                exp_q.push_back(v);
                send_byte(v);
            end
        end
        end_scn("rand_mix");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
